// File: rtl/burst_grant_scheduler.sv
// burst_grant_scheduler: queues timed burst grants and issues start/stop/enable_till to the window generator.
// Optional macro SCHED_GUARD_EN issues start GUARD_CYCLES early and stretches the window by the same amount.
module burst_grant_scheduler #(
  parameter int DEPTH        = 8,
  parameter int CNT_W        = 4,
  parameter int GUARD_CYCLES = 4
) (
  input  logic             clk_in,
  input  logic             reset_n_in,
  input  logic             time_load,
  input  logic [31:0]      time_load_val,
  input  logic             grant_valid,
  output logic             grant_ready,
  input  logic [31:0]      grant_start,
  input  logic [31:0]      grant_len,
  input  logic             abort,
  output logic             start,
  output logic             stop,
  output logic [31:0]      enable_till,
  output logic             busy,
  output logic [31:0]      time_now,
  output logic [CNT_W-1:0] fifo_count,
  output logic             late_drop,
  output logic             zero_drop
);
  localparam int AW = $clog2(DEPTH);
`ifdef SCHED_GUARD_EN
  localparam int LEAD = GUARD_CYCLES;
`else
  localparam int LEAD = 0;
`endif
  typedef enum logic [1:0] {IDLE, HEAD, BUSY} state_t;
  state_t           state_q, state_d;
  logic [31:0]      time_q, time_d, cnt_q, cnt_d, en_q, en_d;
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             stop_q, stop_d, zd_q, zd_d;
  logic [63:0]      mem [DEPTH];
  logic             xfer, push, eval, issue, drop, pop;
  logic [31:0]      head_start, head_len, lead, diff, len_eff;
  logic [32:0]      len_sum;
  always_comb begin
    head_start  = mem[rd_q][63:32];
    head_len    = mem[rd_q][31:0];
    lead        = head_start - 32'(LEAD);
    len_sum     = {1'b0, head_len} + 33'(LEAD);
    len_eff     = len_sum[32] ? '1 : len_sum[31:0];
    diff        = lead - time_q;
    grant_ready = reset_n_in && count_q != CNT_W'(DEPTH) && !abort;
    xfer        = grant_valid && grant_ready;
    push        = xfer && grant_len != '0;
    // the head is judged whenever no window is running, or in the final cycle of one
    eval        = reset_n_in && !abort && count_q != '0 && (state_q != BUSY || cnt_q == 32'd1);
    issue       = eval && diff == '0;
    drop        = eval && diff[31];
    pop         = issue || drop;
    time_d      = time_load ? time_load_val : time_q + 32'd1;
    wr_d        = abort ? '0 : wr_q + AW'(push);
    rd_d        = abort ? '0 : rd_q + AW'(pop);
    count_d     = abort ? '0 : count_q + CNT_W'(push) - CNT_W'(pop);
    en_d        = issue ? len_eff : en_q;
    stop_d      = abort && state_q == BUSY;
    zd_d        = xfer && grant_len == '0;
    cnt_d       = issue ? len_eff : (state_q == BUSY ? cnt_q - 32'd1 : cnt_q);
    state_d     = abort ? IDLE :
                  issue ? BUSY :
                  (state_q == BUSY && cnt_q != 32'd1) ? BUSY :
                  count_d != '0 ? HEAD : IDLE;
    start       = issue;
    late_drop   = drop;
    enable_till = issue ? len_eff : en_q;
    busy        = state_q == BUSY;
    stop        = stop_q;
    zero_drop   = zd_q;
    time_now    = time_q;
    fifo_count  = count_q;
  end
  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      state_q <= IDLE;
      time_q  <= '0;
      cnt_q   <= '0;
      en_q    <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      stop_q  <= 1'b0;
      zd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      stop_q  <= stop_d;
      zd_q    <= zd_d;
    end
  end
  always_ff @(posedge clk_in) begin
    if (push) mem[wr_q] <= {grant_start, grant_len};
  end
endmodule

// File: tb/tb_burst_grant_scheduler.sv
// tb_burst_grant_scheduler: directed checks of grant issue, back-to-back, late/zero drops, wrap, fill and abort.
module tb_burst_grant_scheduler;
  logic        clk = 1'b0, reset_n = 1'b0, time_load = 1'b0, grant_valid = 1'b0, abort = 1'b0;
  logic [31:0] time_load_val = '0, grant_start = '0, grant_len = '0;
  logic        grant_ready, start, stop, busy, late_drop, zero_drop;
  logic [31:0] enable_till, time_now;
  logic [3:0]  fifo_count;
  int          checks = 0, errors = 0;
  int          n_start, n_busy, n_late, n_zero, n_stop;
  logic [31:0] first_start_t, last_start_t, last_en, first_busy_t, last_busy_t;

  burst_grant_scheduler dut (
    .clk_in(clk), .reset_n_in(reset_n), .time_load(time_load), .time_load_val(time_load_val),
    .grant_valid(grant_valid), .grant_ready(grant_ready), .grant_start(grant_start),
    .grant_len(grant_len), .abort(abort), .start(start), .stop(stop), .enable_till(enable_till),
    .busy(busy), .time_now(time_now), .fifo_count(fifo_count), .late_drop(late_drop),
    .zero_drop(zero_drop)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (start) begin
      if (n_start == 0) first_start_t = time_now;
      last_start_t = time_now;
      last_en = enable_till;
      n_start++;
    end
    if (busy) begin
      if (n_busy == 0) first_busy_t = time_now;
      last_busy_t = time_now;
      n_busy++;
    end
    if (late_drop) n_late++;
    if (zero_drop) n_zero++;
    if (stop) n_stop++;
  end

  task automatic clr();
    n_start = 0; n_busy = 0; n_late = 0; n_zero = 0; n_stop = 0;
    first_start_t = '0; last_start_t = '0; last_en = '0; first_busy_t = '0; last_busy_t = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_to(input logic [31:0] t);
    for (int k = 0; k < 3000 && time_now !== t; k++) tick();
    chk("run_to", time_now, t);
  endtask

  task automatic put(input logic [31:0] s, input logic [31:0] l);
    grant_valid = 1'b1; grant_start = s; grant_len = l;
    tick();
    grant_valid = 1'b0;
  endtask

  task automatic load(input logic [31:0] v);
    time_load = 1'b1; time_load_val = v;
    tick();
    time_load = 1'b0;
  endtask

  initial begin
    clr();
    tick();
    tick();
    chk("rst_ready", {31'd0, grant_ready}, 32'd0);
    chk("rst_en", enable_till, 32'd0);
    chk("rst_out", {28'd0, start, stop, busy, zero_drop}, 32'd0);
    reset_n = 1'b1;
    #1;
    chk("rel_time", time_now, 32'd0);
    chk("rel_count", {28'd0, fifo_count}, 32'd0);
    chk("rel_ready", {31'd0, grant_ready}, 32'd1);
    put(32'd20, 32'd5);
    chk("t1_count", {28'd0, fifo_count}, 32'd1);
    run_to(32'd30);
    chk("t1_nstart", n_start, 32'd1);
    chk("t1_start_t", last_start_t, 32'd20);
    chk("t1_en", last_en, 32'd5);
    chk("t1_nbusy", n_busy, 32'd5);
    chk("t1_busy_first", first_busy_t, 32'd21);
    chk("t1_busy_last", last_busy_t, 32'd25);
    chk("t1_count_end", {28'd0, fifo_count}, 32'd0);
    chk("t1_en_hold", enable_till, 32'd5);
    clr();
    put(32'd100, 32'd10);
    put(32'd110, 32'd3);
    run_to(32'd120);
    chk("t2_nstart", n_start, 32'd2);
    chk("t2_start0", first_start_t, 32'd100);
    chk("t2_start1", last_start_t, 32'd110);
    chk("t2_nbusy", n_busy, 32'd13);
    chk("t2_busy_first", first_busy_t, 32'd101);
    chk("t2_busy_last", last_busy_t, 32'd113);
    chk("t2_en", enable_till, 32'd3);
    load(32'd50);
    chk("t3_load", time_now, 32'd50);
    clr();
    put(32'd30, 32'd4);
    tick();
    tick();
    chk("t3_nlate", n_late, 32'd1);
    chk("t3_nstart", n_start, 32'd0);
    chk("t3_count", {28'd0, fifo_count}, 32'd0);
    load(32'hFFFF_FFF0);
    clr();
    put(32'hFFFF_FFFE, 32'd2);
    run_to(32'd5);
    chk("t3w_nstart", n_start, 32'd1);
    chk("t3w_start_t", last_start_t, 32'hFFFF_FFFE);
    chk("t3w_nbusy", n_busy, 32'd2);
    chk("t3w_busy_last", last_busy_t, 32'd0);
    chk("t3w_nlate", n_late, 32'd0);
    clr();
    for (int i = 0; i < 3; i++) put(32'd1000 + 32'(16 * i), 32'd1);
    put(32'd2000, 32'd0);
    chk("t4_zero_pulse", {31'd0, zero_drop}, 32'd1);
    chk("t4_zero_count", {28'd0, fifo_count}, 32'd3);
    tick();
    chk("t4_zero_end", {31'd0, zero_drop}, 32'd0);
    for (int i = 3; i < 8; i++) put(32'd1000 + 32'(16 * i), 32'd1);
    chk("t4_full_count", {28'd0, fifo_count}, 32'd8);
    chk("t4_full_ready", {31'd0, grant_ready}, 32'd0);
    put(32'd3000, 32'd1);
    chk("t4_full_hold", {28'd0, fifo_count}, 32'd8);
    chk("t4_nzero", n_zero, 32'd1);
    clr();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5i_count", {28'd0, fifo_count}, 32'd0);
    chk("t5i_stop", {31'd0, stop}, 32'd0);
    tick();
    chk("t5i_nstop", n_stop, 32'd0);
    load(32'd300);
    clr();
    put(32'd310, 32'd50);
    put(32'd400, 32'd1);
    put(32'd410, 32'd1);
    put(32'd420, 32'd1);
    run_to(32'd320);
    chk("t5_busy", {31'd0, busy}, 32'd1);
    chk("t5_count", {28'd0, fifo_count}, 32'd3);
    abort = 1'b1; grant_valid = 1'b1; grant_start = 32'd500; grant_len = 32'd5;
    #1;
    chk("t5_abort_ready", {31'd0, grant_ready}, 32'd0);
    tick();
    abort = 1'b0; grant_valid = 1'b0;
    chk("t5_stop", {31'd0, stop}, 32'd1);
    chk("t5_busy_off", {31'd0, busy}, 32'd0);
    chk("t5_count_off", {28'd0, fifo_count}, 32'd0);
    chk("t5_en_hold", enable_till, 32'd50);
    tick();
    chk("t5_stop_end", {31'd0, stop}, 32'd0);
    repeat (20) tick();
    chk("t5_nstop", n_stop, 32'd1);
    chk("t5_nstart", n_start, 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
